// File: rtl/act_pkg.sv
// Shared types and constants for the activation-mux layer sequencer.
// Also holds the act_mux config word layout and the command legality rule.
package act_pkg;

    localparam int unsigned IMG_DIM_W = 12;
    localparam int unsigned CH_W      = 16;
    localparam int unsigned MAX_CH    = 256;
    localparam int unsigned LEN_W     = 32;
    localparam int unsigned PROD_W    = 30;
    localparam int unsigned AREA_W    = 2 * IMG_DIM_W;
    localparam int unsigned GRP_W     = 6;
    localparam int unsigned CFG_W     = 32;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ST_W      = 3;

    localparam int unsigned IMG_W_LSB = 0;
    localparam int unsigned IMG_H_LSB = 12;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_CFG0  = 3'd2,
        S_CFG1  = 3'd3,
        S_RUN   = 3'd4,
        S_DRAIN = 3'd5,
        S_FIN   = 3'd6
    } state_e;

    typedef struct packed {
        logic [IMG_DIM_W-1:0] img_h;
        logic [IMG_DIM_W-1:0] img_w;
        logic [CH_W-1:0]      ch_num;
    } layer_cmd_t;

    function automatic logic cmd_illegal(input layer_cmd_t c);
        return (c.img_h == '0) || (c.img_w == '0) || (c.ch_num == '0) ||
               (c.ch_num > CH_W'(MAX_CH));
    endfunction

    // First act_mux config word: {8'h00, img_h, img_w}.
    function automatic logic [CFG_W-1:0] cfg_word0(input layer_cmd_t c);
        logic [CFG_W-1:0] w;
        w = '0;
        w[IMG_H_LSB +: IMG_DIM_W] = c.img_h;
        w[IMG_W_LSB +: IMG_DIM_W] = c.img_w;
        return w;
    endfunction

endpackage

// File: rtl/act_mux_ctrl_len_calc.sv
// Two-stage registered beat-count calculator: total_len = h * w * ceil(ch/8) * 2.
// Stage 1 forms the pixel area and group count, stage 2 the final product.
module len_calc
    import act_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [IMG_DIM_W-1:0] img_h_i,
    input  logic [IMG_DIM_W-1:0] img_w_i,
    input  logic [CH_W-1:0]      ch_num_i,
    output logic                 valid_o,
    output logic [LEN_W-1:0]     total_len_o
);

    logic [AREA_W-1:0] area_q, area_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic              s1_vld_q;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              s2_vld_q;
    logic [CH_W:0]     ch_pad;
    logic [PROD_W-1:0] prod;

    // Legal commands are at most 4095*4095*32, so the area*groups product fits in 30 bits.
    always_comb begin
        ch_pad = {1'b0, ch_num_i} + (CH_W + 1)'(7);
        grp_d  = GRP_W'(ch_pad >> 3);
        area_d = AREA_W'(img_h_i) * AREA_W'(img_w_i);
        prod   = PROD_W'(area_q) * PROD_W'(grp_q);
        len_d  = LEN_W'(prod) << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            area_q   <= '0;
            grp_q    <= '0;
            s1_vld_q <= 1'b0;
            len_q    <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= valid_i;
            s2_vld_q <= s1_vld_q;
            if (valid_i) begin
                area_q <= area_d;
                grp_q  <= grp_d;
            end
            if (s1_vld_q) begin
                len_q <= len_d;
            end
        end
    end

    assign valid_o     = s2_vld_q;
    assign total_len_o = len_q;

endmodule

// File: rtl/act_mux_ctrl.sv
// Layer sequencer in front of act_mux: configures it, gates the activation stream
// to exactly total_len beats and signals completion from the act output monitor.
module act_mux_ctrl
    import act_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [IMG_DIM_W-1:0] cmd_img_h,
    input  logic [IMG_DIM_W-1:0] cmd_img_w,
    input  logic [CH_W-1:0]      cmd_ch_num,
    output logic                 m_config_valid,
    input  logic                 m_config_ready,
    output logic [CFG_W-1:0]     m_config_data,
    input  logic                 up_data_valid,
    output logic                 up_data_ready,
    input  logic [DATA_W-1:0]    up_data,
    output logic                 dn_data_valid,
    input  logic                 dn_data_ready,
    output logic [DATA_W-1:0]    dn_data,
    input  logic                 act_valid_mon,
    input  logic                 act_ready_mon,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ST_W-1:0]      status
);

    state_e           state_q, state_d;
    logic [CFG_W-1:0] cfg0_q, cfg0_d;
    logic [LEN_W-1:0] total_len_q, total_len_d;
    logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
    logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    layer_cmd_t       cmd_in;
    logic             calc_start;
    logic             len_vld;
    logic [LEN_W-1:0] len_total;
    logic             gate;
    logic             in_hs;
    logic             out_hs;
    logic             out_cnt_en;

    assign cmd_in = '{img_h: cmd_img_h, img_w: cmd_img_w, ch_num: cmd_ch_num};

    len_calc u_len_calc (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_i     (calc_start),
        .img_h_i     (cmd_img_h),
        .img_w_i     (cmd_img_w),
        .ch_num_i    (cmd_ch_num),
        .valid_o     (len_vld),
        .total_len_o (len_total)
    );

    // Stream gate is combinational so the beat stops on the exact count with no slip.
    assign gate       = (state_q == S_RUN) && (in_cnt_q < total_len_q);
    assign out_cnt_en = (state_q == S_CFG1) || (state_q == S_RUN) ||
                        (state_q == S_DRAIN) || (state_q == S_FIN);
    assign in_hs      = up_data_valid & up_data_ready;
    assign out_hs     = act_valid_mon & act_ready_mon & out_cnt_en;

    always_comb begin
        state_d     = state_q;
        cfg0_d      = cfg0_q;
        total_len_d = total_len_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        err_d       = err_q;
        done_d      = 1'b0;
        calc_start  = 1'b0;

        if (in_hs) begin
            in_cnt_d = in_cnt_q + LEN_W'(1);
        end
        // Output counter saturates; any handshake past the layer length is a monitor violation.
        if (out_hs) begin
            if (out_cnt_q < total_len_q) begin
                out_cnt_d = out_cnt_q + LEN_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    err_d  = 1'b0;
                    cfg0_d = cfg_word0(cmd_in);
                    if (cmd_illegal(cmd_in)) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        calc_start  = 1'b1;
                        in_cnt_d    = '0;
                        out_cnt_d   = '0;
                        total_len_d = '0;
                        state_d     = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (len_vld) begin
                    total_len_d = len_total;
                    state_d     = S_CFG0;
                end
            end
            S_CFG0: begin
                if (m_config_ready) begin
                    state_d = S_CFG1;
                end
            end
            S_CFG1: begin
                if (m_config_ready) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_cnt_d == total_len_q) begin
                    if (out_cnt_d == total_len_q) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_d == total_len_q) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg0_q      <= '0;
            total_len_q <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg0_q      <= cfg0_d;
            total_len_q <= total_len_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        m_config_valid = 1'b0;
        m_config_data  = '0;
        if (state_q == S_CFG0) begin
            m_config_valid = 1'b1;
            m_config_data  = cfg0_q;
        end else if (state_q == S_CFG1) begin
            m_config_valid = 1'b1;
            m_config_data  = total_len_q;
        end
    end

    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign up_data_ready = dn_data_ready & gate;
    assign dn_data_valid = up_data_valid & gate;
    assign dn_data       = up_data;
    assign done          = done_q;
    assign err           = err_q;
    assign status        = state_q;

endmodule

// File: tb/tb_act_mux_ctrl.sv
// Self-checking bench for act_mux_ctrl: table of layer commands plus random commands,
// checked cycle by cycle against a transaction-level model of the layer sequence.
module tb_act_mux_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_img_h;
    logic [11:0] cmd_img_w;
    logic [15:0] cmd_ch_num;
    logic        m_config_valid;
    logic        m_config_ready;
    logic [31:0] m_config_data;
    logic        up_data_valid;
    logic        up_data_ready;
    logic [63:0] up_data;
    logic        dn_data_valid;
    logic        dn_data_ready;
    logic [63:0] dn_data;
    logic        act_valid_mon;
    logic        act_ready_mon;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  status;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    act_mux_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_img_h      (cmd_img_h),
        .cmd_img_w      (cmd_img_w),
        .cmd_ch_num     (cmd_ch_num),
        .m_config_valid (m_config_valid),
        .m_config_ready (m_config_ready),
        .m_config_data  (m_config_data),
        .up_data_valid  (up_data_valid),
        .up_data_ready  (up_data_ready),
        .up_data        (up_data),
        .dn_data_valid  (dn_data_valid),
        .dn_data_ready  (dn_data_ready),
        .dn_data        (dn_data),
        .act_valid_mon  (act_valid_mon),
        .act_ready_mon  (act_ready_mon),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .status         (status)
    );

    typedef struct {
        int          h;
        int          w;
        int          ch;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          illegal;
        int          stall;
        int          up_mode;
        int          dn_mode;
        int          act_mode;
        int          rst_at;
        bit          extra;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive_idle();
        cmd_valid      = 1'b0;
        m_config_ready = 1'b0;
        up_data_valid  = 1'b0;
        dn_data_ready  = 1'b0;
        act_valid_mon  = 1'b0;
        act_ready_mon  = 1'b0;
    endtask

    task automatic send_cmd(input int h, input int w, input int ch);
        @(negedge clk);
        drive_idle();
        cmd_valid  = 1'b1;
        cmd_img_h  = 12'(h);
        cmd_img_w  = 12'(w);
        cmd_ch_num = 16'(ch);
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);
    endtask

    task automatic run_illegal(input int h, input int w, input int ch);
        send_cmd(h, w, ch);
        @(negedge clk);
        drive_idle();
        #1;
        chk("illegal_done", done, 1);
        chk("illegal_err", err, 1);
        chk("illegal_status", status, 0);
        chk("illegal_busy", busy, 0);
        chk("illegal_cfg_valid", m_config_valid, 0);
        @(negedge clk);
        #1;
        chk("illegal_done_once", done, 0);
        chk("illegal_err_sticky", err, 1);
        chk("illegal_cfg_valid2", m_config_valid, 0);
    endtask

    // Model: config words appear from the 3rd cycle after acceptance, beats flow only
    // after both config handshakes and until len beats, done follows the last act output.
    task automatic run_layer(input int h, input int w, input int ch,
                             input logic [31:0] ew0, input logic [31:0] ew1,
                             input int stall, input int up_mode, input int dn_mode,
                             input int act_mode, input int rst_at, input bit extra);
        int  k, acc, acts, pend, cfg_hs, done_at, stall_left, len;
        bit  finished, was_reset, tgl, exp_cfg_v, exp_gate, fire;
        k = 0; acc = 0; acts = 0; pend = 0; cfg_hs = 0; done_at = -1;
        stall_left = stall; finished = 0; was_reset = 0; tgl = 0;
        len = int'(ew1);
        send_cmd(h, w, ch);
        while (!finished && k < 30000) begin
            @(negedge clk);
            k++;
            cmd_valid = 1'b0;
            if (rst_at >= 0 && cfg_hs == 2 && acc == rst_at) begin
                rst_n         = 1'b0;
                up_data_valid = 1'b0;
                act_valid_mon = 1'b0;
                act_ready_mon = 1'b0;
                @(negedge clk);
                rst_n          = 1'b1;
                up_data_valid  = 1'b1;
                dn_data_ready  = 1'b1;
                m_config_ready = 1'b1;
                #1;
                chk("rst_status", status, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_cfg_valid", m_config_valid, 0);
                chk("rst_up_ready", up_data_ready, 0);
                chk("rst_dn_valid", dn_data_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    drive_idle();
                    #1;
                    chk("rst_no_done", done, 0);
                end
                was_reset = 1;
                finished  = 1;
                break;
            end
            exp_cfg_v = (k >= 3) && (cfg_hs < 2);
            if (exp_cfg_v && cfg_hs == 0 && stall_left > 0) begin
                m_config_ready = 1'b0;
                stall_left--;
            end else begin
                m_config_ready = (stall > 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            up_data_valid = (up_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            up_data       = {$urandom, $urandom};
            tgl           = ~tgl;
            dn_data_ready = (dn_mode == 1) ? 1'b1 : (dn_mode == 2) ? tgl : 1'($urandom_range(0, 1));
            #1;
            exp_gate = (cfg_hs == 2) && (acc < len);
            chk("up_data_ready", up_data_ready, dn_data_ready && exp_gate);
            chk("dn_data_valid", dn_data_valid, up_data_valid && exp_gate);
            if (dn_data_valid) chk("dn_data", dn_data, up_data);
            chk("m_config_valid", m_config_valid, exp_cfg_v);
            if (exp_cfg_v) chk("m_config_data", m_config_data, (cfg_hs == 0) ? ew0 : ew1);
            chk("done", done, k == done_at);
            chk("busy", busy, 1);
            if (k <= 2) chk("status_calc", status, 1);
            if (k == 1) begin
                chk("cmd_ready_busy", cmd_ready, 0);
                chk("err_cleared", err, 0);
            end
            if (exp_cfg_v && m_config_ready) cfg_hs++;
            if (up_data_valid && dn_data_ready && exp_gate) begin
                acc++;
                pend++;
            end
            if (k == done_at) begin
                fire     = extra;
                finished = 1;
            end else begin
                fire = (pend > 0) && (act_mode == 1 || $urandom_range(0, 2) != 0);
                if (fire) begin
                    pend--;
                    acts++;
                    if (acts == len) done_at = k + 1;
                end
            end
            act_valid_mon = fire | ($urandom_range(0, 3) == 0);
            act_ready_mon = fire;
        end
        if (!was_reset) begin
            chk("layer_completes", finished, 1);
            chk("beats_passed", 64'(acc), 64'(len));
            @(negedge clk);
            drive_idle();
            #1;
            chk("post_status", status, 0);
            chk("post_cmd_ready", cmd_ready, 1);
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_err", err, extra);
        end
    endtask

    initial begin
        drive_idle();
        cmd_img_h  = '0;
        cmd_img_w  = '0;
        cmd_ch_num = '0;
        up_data    = '0;
        rst_n      = 1'b0;

        // Reset state, with handshake inputs asserted so gating is exercised
        @(negedge clk);
        up_data_valid  = 1'b1;
        dn_data_ready  = 1'b1;
        m_config_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_cfg_valid", m_config_valid, 0);
        chk("reset_cfg_data", m_config_data, 0);
        chk("reset_up_ready", up_data_ready, 0);
        chk("reset_dn_valid", dn_data_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_status", status, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();

        tbl[0]  = '{2, 3, 8, 32'h0000_2003, 32'd12, 1'b0, 0, 0, 0, 0, -1, 1'b0};
        tbl[1]  = '{4, 4, 12, 32'h0000_4004, 32'd64, 1'b0, 0, 1, 1, 0, -1, 1'b0};
        tbl[2]  = '{3, 5, 16, 32'h0000_3005, 32'd60, 1'b0, 5, 0, 0, 0, -1, 1'b0};
        tbl[3]  = '{0, 3, 8, 32'h0, 32'h0, 1'b1, 0, 0, 0, 0, -1, 1'b0};
        tbl[4]  = '{2, 2, 0, 32'h0, 32'h0, 1'b1, 0, 0, 0, 0, -1, 1'b0};
        tbl[5]  = '{2, 2, 257, 32'h0, 32'h0, 1'b1, 0, 0, 0, 0, -1, 1'b0};
        tbl[6]  = '{2, 2, 7, 32'h0000_2002, 32'd8, 1'b0, 0, 1, 2, 1, -1, 1'b1};
        tbl[7]  = '{1, 1, 256, 32'h0000_1001, 32'd64, 1'b0, 0, 0, 0, 0, -1, 1'b0};
        tbl[8]  = '{4095, 1, 1, 32'h00FF_F001, 32'd8190, 1'b0, 0, 1, 1, 1, -1, 1'b0};
        tbl[9]  = '{2, 3, 8, 32'h0000_2003, 32'd12, 1'b0, 0, 1, 1, 0, 5, 1'b0};
        tbl[10] = '{4, 0, 8, 32'h0, 32'h0, 1'b1, 0, 0, 0, 0, -1, 1'b0};

        foreach (tbl[i]) begin
            if (tbl[i].illegal) run_illegal(tbl[i].h, tbl[i].w, tbl[i].ch);
            else run_layer(tbl[i].h, tbl[i].w, tbl[i].ch, tbl[i].w0, tbl[i].w1,
                           tbl[i].stall, tbl[i].up_mode, tbl[i].dn_mode,
                           tbl[i].act_mode, tbl[i].rst_at, tbl[i].extra);
        end

        // Random commands, expectations derived from the layer arithmetic
        for (int r = 0; r < 12; r++) begin
            int h, w, ch;
            h  = $urandom_range(1, 3);
            w  = $urandom_range(1, 3);
            ch = $urandom_range(1, 64);
            case ($urandom_range(0, 7))
                0: ch = 0;
                1: ch = $urandom_range(257, 300);
                2: h  = 0;
                default: ;
            endcase
            if (h == 0 || w == 0 || ch == 0 || ch > 256) begin
                run_illegal(h, w, ch);
            end else begin
                run_layer(h, w, ch, 32'((h << 12) | w), 32'(h * w * ((ch + 7) / 8) * 2),
                          $urandom_range(0, 3), $urandom_range(0, 1),
                          $urandom_range(0, 2), $urandom_range(0, 1), -1, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
